// File: rtl/symcounter_pkg.sv
// rtl/symcounter_pkg.sv - shared phase encodings and widths for the SymCounter sequencer
package symcounter_pkg;

    localparam int PHASE_W = 3;
    localparam int SCORE_W = 4;
    localparam int SEC_W   = 4;

    typedef enum logic [PHASE_W-1:0] {
        PH_IDLE   = 3'd0,
        PH_READY  = 3'd1,
        PH_SHOW   = 3'd2,
        PH_ANSWER = 3'd3,
        PH_POST   = 3'd4,
        PH_DONE   = 3'd5
    } phase_t;

    // Score increment that sticks at the top value instead of wrapping.
    function automatic logic [SCORE_W-1:0] satInc(input logic [SCORE_W-1:0] v);
        return (v == {SCORE_W{1'b1}}) ? v : v + SCORE_W'(1);
    endfunction

endpackage

// File: rtl/sec_timer.sv
// rtl/sec_timer.sv - loadable seconds down-counter with expire pulse
module sec_timer
    import symcounter_pkg::*;
(
    input  logic             Clk100M,
    input  logic             Rst_n,
    input  logic             load,
    input  logic [SEC_W-1:0] loadVal,
    input  logic             tick,
    output logic [SEC_W-1:0] secLeft,
    output logic             expire
);

    // The last second is never decremented to zero: the owner reloads on expire.
    assign expire = tick && (secLeft == SEC_W'(1));

    // Load has priority over a coincident tick so a phase change always starts fresh.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            secLeft <= '0;
        end else if (load) begin
            secLeft <= loadVal;
        end else if (tick && (secLeft > SEC_W'(1))) begin
            secLeft <= secLeft - SEC_W'(1);
        end
    end

endmodule

// File: rtl/symcount_game_sequencer.sv
// rtl/symcount_game_sequencer.sv - round sequencer and scorekeeper for the SymCounter game
module symcount_game_sequencer
    import symcounter_pkg::*;
#(
    parameter int READY_SEC          = 3,
    parameter int SHOW_SEC           = 10,
    parameter int ANSWER_TIMEOUT_SEC = 15,
    parameter int POST_SEC           = 3,
    parameter int NUM_ROUNDS         = 5
) (
    input  logic               Clk100M,
    input  logic               Rst_n,
    input  logic               Clk1Hz,
    input  logic               startBtn,
    input  logic               abortBtn,
    input  logic               postSig,
    input  logic               stopCount,
    input  logic [7:0]         userCount,
    input  logic [7:0]         trueCount,
    output logic [PHASE_W-1:0] phase,
    output logic               newRound,
    output logic               symbolTick,
    output logic               countEn,
    output logic               answerSig,
    output logic [3:0]         roundNum,
    output logic [SCORE_W-1:0] score,
    output logic [SEC_W-1:0]   secLeft,
    output logic               gameDone
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    phase_t           state;
    phase_t           nextState;
    logic             firstCycle;
    logic             timerLoad;
    logic [SEC_W-1:0] timerLoadVal;
    logic             timerTick;
    logic             timerExpire;
    logic             abortHit;
    logic             startHit;
    logic             scoreHit;

    // Duration loaded into the timer when a phase is entered; untimed phases park at 0.
    function automatic logic [SEC_W-1:0] secFor(input phase_t p);
        case (p)
            PH_READY:  return SEC_W'(READY_SEC);
            PH_SHOW:   return SEC_W'(SHOW_SEC);
            PH_ANSWER: return SEC_W'(ANSWER_TIMEOUT_SEC);
            PH_POST:   return SEC_W'(POST_SEC);
            default:   return '0;
        endcase
    endfunction

    assign abortHit  = abortBtn && (state != PH_IDLE);
    assign startHit  = startBtn && ((state == PH_IDLE) || (state == PH_DONE));
    assign scoreHit  = (state == PH_ANSWER) && postSig && (userCount == trueCount);
    assign timerTick = Clk1Hz && !firstCycle;
    assign phase     = state;

    sec_timer uTimer (
        .Clk100M (Clk100M),
        .Rst_n   (Rst_n),
        .load    (timerLoad),
        .loadVal (timerLoadVal),
        .tick    (timerTick),
        .secLeft (secLeft),
        .expire  (timerExpire)
    );

    // Phase register.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= PH_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next phase, honouring abort > start > postSig > second tick.
    always_comb begin
        nextState    = state;
        timerLoad    = 1'b0;
        timerLoadVal = '0;
        if (abortHit) begin
            nextState = PH_IDLE;
        end else begin
            case (state)
                PH_IDLE, PH_DONE: if (startHit) nextState = PH_READY;
                PH_READY:         if (timerExpire) nextState = PH_SHOW;
                PH_SHOW:          if (timerExpire) nextState = PH_ANSWER;
                PH_ANSWER:        if (postSig || timerExpire) nextState = PH_POST;
                PH_POST: begin
                    if (timerExpire) begin
                        nextState = (roundNum == LAST_ROUND) ? PH_DONE : PH_READY;
                    end
                end
                default:          nextState = PH_IDLE;
            endcase
        end
        timerLoad    = (nextState != state);
        timerLoadVal = secFor(nextState);
    end

    // Registered strobes, enables and score bookkeeping, all derived from the upcoming phase.
    always_ff @(posedge Clk100M or negedge Rst_n) begin
        if (!Rst_n) begin
            newRound   <= 1'b0;
            symbolTick <= 1'b0;
            countEn    <= 1'b0;
            answerSig  <= 1'b0;
            gameDone   <= 1'b0;
            firstCycle <= 1'b0;
            roundNum   <= '0;
            score      <= '0;
        end else begin
            newRound   <= (nextState == PH_READY) && (state != PH_READY);
            symbolTick <= !abortHit && Clk1Hz && (state == PH_SHOW);
            countEn    <= (nextState == PH_SHOW) && !stopCount;
            answerSig  <= (nextState == PH_ANSWER) && (state != PH_ANSWER);
            gameDone   <= (nextState == PH_DONE);
            firstCycle <= timerLoad;
            if (abortHit) begin
                roundNum <= '0;
                score    <= '0;
            end else if (startHit) begin
                roundNum <= 4'd1;
                score    <= '0;
            end else begin
                if ((state == PH_POST) && (nextState == PH_READY)) begin
                    roundNum <= roundNum + 4'd1;
                end
                if (scoreHit) begin
                    score <= satInc(score);
                end
            end
        end
    end

endmodule

// File: tb/tb_symcount_game_sequencer.sv
// tb/tb_symcount_game_sequencer.sv - directed self-checking bench for symcount_game_sequencer
module tb_symcount_game_sequencer;

    localparam int TICK_GAP = 100;

    logic       Clk100M = 1'b0;
    logic       Rst_n;
    logic       Clk1Hz;
    logic       startBtn;
    logic       abortBtn;
    logic       postSig;
    logic       stopCount;
    logic [7:0] userCount;
    logic [7:0] trueCount;
    logic [2:0] phase;
    logic       newRound;
    logic       symbolTick;
    logic       countEn;
    logic       answerSig;
    logic [3:0] roundNum;
    logic [3:0] score;
    logic [3:0] secLeft;
    logic       gameDone;

    int total = 0;
    int bad = 0;
    int symSeen = 0;
    int answerSeen = 0;
    int newRoundSeen = 0;

    always #5 Clk100M = ~Clk100M;

    symcount_game_sequencer #(
        .READY_SEC          (1),
        .SHOW_SEC           (2),
        .ANSWER_TIMEOUT_SEC (3),
        .POST_SEC           (1),
        .NUM_ROUNDS         (2)
    ) dut (
        .Clk100M    (Clk100M),
        .Rst_n      (Rst_n),
        .Clk1Hz     (Clk1Hz),
        .startBtn   (startBtn),
        .abortBtn   (abortBtn),
        .postSig    (postSig),
        .stopCount  (stopCount),
        .userCount  (userCount),
        .trueCount  (trueCount),
        .phase      (phase),
        .newRound   (newRound),
        .symbolTick (symbolTick),
        .countEn    (countEn),
        .answerSig  (answerSig),
        .roundNum   (roundNum),
        .score      (score),
        .secLeft    (secLeft),
        .gameDone   (gameDone)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic clkStep();
        @(posedge Clk100M);
        #1;
        if (symbolTick) symSeen++;
        if (answerSig) answerSeen++;
        if (newRound) newRoundSeen++;
    endtask

    task automatic secTick();
        repeat (TICK_GAP - 1) clkStep();
        Clk1Hz = 1'b1;
        clkStep();
        Clk1Hz = 1'b0;
    endtask

    task automatic checkAllClear(input string tag);
        checkVal({tag, " phase"}, 32'(phase), 0);
        checkVal({tag, " outs"}, {newRound, symbolTick, countEn, answerSig, gameDone}, 0);
        checkVal({tag, " roundNum"}, 32'(roundNum), 0);
        checkVal({tag, " score"}, 32'(score), 0);
        checkVal({tag, " secLeft"}, 32'(secLeft), 0);
    endtask

    initial begin
        Rst_n = 1'b0;
        Clk1Hz = 1'b0;
        startBtn = 1'b0;
        abortBtn = 1'b0;
        postSig = 1'b0;
        stopCount = 1'b0;
        userCount = 8'd0;
        trueCount = 8'd0;
        repeat (3) clkStep();
        checkAllClear("reset");
        Rst_n = 1'b1;
        repeat (2) clkStep();

        // 1: start, entry-cycle tick ignored, READY -> SHOW
        newRoundSeen = 0;
        startBtn = 1'b1;
        clkStep();
        startBtn = 1'b0;
        checkVal("t1 phase ready", 32'(phase), 1);
        checkVal("t1 newRound", 32'(newRound), 1);
        checkVal("t1 roundNum", 32'(roundNum), 1);
        checkVal("t1 score", 32'(score), 0);
        checkVal("t1 secLeft", 32'(secLeft), 1);
        Clk1Hz = 1'b1;
        clkStep();
        Clk1Hz = 1'b0;
        checkVal("t1 entry tick ignored", 32'(phase), 1);
        checkVal("t1 newRound once", 32'(newRound), 0);
        secTick();
        checkVal("t1 phase show", 32'(phase), 2);
        checkVal("t1 countEn", 32'(countEn), 1);
        checkVal("t1 show secLeft", 32'(secLeft), 2);
        checkVal("t1 newRound count", newRoundSeen, 1);

        // 2: SHOW symbol ticks, stopCount, entry into ANSWER
        symSeen = 0;
        answerSeen = 0;
        secTick();
        checkVal("t2 symbolTick late", 32'(symbolTick), 1);
        checkVal("t2 secLeft", 32'(secLeft), 1);
        stopCount = 1'b1;
        clkStep();
        checkVal("t2 stopCount clears", 32'(countEn), 0);
        checkVal("t2 symbolTick one cycle", 32'(symbolTick), 0);
        stopCount = 1'b0;
        clkStep();
        checkVal("t2 countEn back", 32'(countEn), 1);
        secTick();
        checkVal("t2 phase answer", 32'(phase), 3);
        checkVal("t2 countEn off", 32'(countEn), 0);
        checkVal("t2 answerSig", 32'(answerSig), 1);
        checkVal("t2 answer secLeft", 32'(secLeft), 3);
        clkStep();
        checkVal("t2 answerSig one cycle", 32'(answerSig), 0);
        checkVal("t2 symbolTick total", symSeen, 2);
        checkVal("t2 answerSig total", answerSeen, 1);

        // 3: correct answer via postSig, then next round
        userCount = 8'd10;
        trueCount = 8'd10;
        postSig = 1'b1;
        clkStep();
        postSig = 1'b0;
        checkVal("t3 score", 32'(score), 1);
        checkVal("t3 phase post", 32'(phase), 4);
        checkVal("t3 post secLeft", 32'(secLeft), 1);
        secTick();
        checkVal("t3 roundNum", 32'(roundNum), 2);
        checkVal("t3 newRound", 32'(newRound), 1);
        checkVal("t3 phase ready", 32'(phase), 1);

        // 4: wrong count, answer times out, game ends
        userCount = 8'd7;
        trueCount = 8'd9;
        secTick();
        secTick();
        secTick();
        checkVal("t4 phase answer", 32'(phase), 3);
        secTick();
        secTick();
        checkVal("t4 secLeft before timeout", 32'(secLeft), 1);
        checkVal("t4 still answer", 32'(phase), 3);
        secTick();
        checkVal("t4 forced post", 32'(phase), 4);
        checkVal("t4 score kept", 32'(score), 1);
        secTick();
        checkVal("t4 phase done", 32'(phase), 5);
        checkVal("t4 gameDone", 32'(gameDone), 1);
        checkVal("t4 roundNum held", 32'(roundNum), 2);
        checkVal("t4 done secLeft", 32'(secLeft), 0);
        userCount = 8'd9;
        postSig = 1'b1;
        clkStep();
        postSig = 1'b0;
        checkVal("t4 postSig in done ignored", 32'(score), 1);

        // 5: restart from DONE, start ignored in SHOW, postSig with final timeout tick
        startBtn = 1'b1;
        clkStep();
        startBtn = 1'b0;
        checkVal("t5 restart roundNum", 32'(roundNum), 1);
        checkVal("t5 restart score", 32'(score), 0);
        checkVal("t5 restart gameDone", 32'(gameDone), 0);
        secTick();
        startBtn = 1'b1;
        clkStep();
        startBtn = 1'b0;
        checkVal("t5 start in show phase", 32'(phase), 2);
        checkVal("t5 start in show secLeft", 32'(secLeft), 2);
        checkVal("t5 start in show newRound", 32'(newRound), 0);
        secTick();
        secTick();
        userCount = 8'd5;
        trueCount = 8'd5;
        secTick();
        secTick();
        repeat (TICK_GAP - 1) clkStep();
        Clk1Hz = 1'b1;
        postSig = 1'b1;
        clkStep();
        Clk1Hz = 1'b0;
        postSig = 1'b0;
        checkVal("t5 coincident phase", 32'(phase), 4);
        checkVal("t5 coincident score", 32'(score), 1);

        // 6: abort mid-SHOW, async reset mid-ANSWER
        secTick();
        secTick();
        repeat (5) clkStep();
        checkVal("t6 in show", 32'(phase), 2);
        abortBtn = 1'b1;
        clkStep();
        abortBtn = 1'b0;
        checkAllClear("t6 abort");
        startBtn = 1'b1;
        clkStep();
        startBtn = 1'b0;
        secTick();
        secTick();
        secTick();
        repeat (3) clkStep();
        checkVal("t6 in answer", 32'(phase), 3);
        Rst_n = 1'b0;
        #1;
        checkAllClear("t6 async reset");
        clkStep();
        Rst_n = 1'b1;
        clkStep();
        checkVal("t6 idle after reset", 32'(phase), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/symcount_game_sequencer.md
Name: symcount_game_sequencer

Overview:
Top-level round sequencer for the SymCounter game. It steps through the game phases: ready countdown, symbol showing with user counting, the answer period, and the post-answer hold. It drives the answer-period block through answerSig, and consumes that block's postSig and stopCount. It keeps score against the symbol generator's true count over a fixed number of rounds.

Parameters:
READY_SEC, 3, seconds of countdown before symbols are shown
SHOW_SEC, 10, seconds symbols are shown and counting is enabled
ANSWER_TIMEOUT_SEC, 15, seconds to wait for postSig before forcing POST
POST_SEC, 3, seconds to hold in POST before the next round
NUM_ROUNDS, 5, rounds per game (1..15)

Ports:
Clk100M in 1 system clock, 100 MHz
Rst_n in 1 asynchronous active-low reset
Clk1Hz in 1 one-Clk100M-cycle tick, once per second (not a clock)
startBtn in 1 debounced single-cycle start pulse
abortBtn in 1 debounced single-cycle abort pulse
postSig in 1 pulse from the answer period: answer display finished
stopCount in 1 level from the answer period: freeze user counting
userCount in 8 player's count
trueCount in 8 actual symbol count from the symbol generator
phase out 3 current state encoding
newRound out 1 one-cycle pulse: symbol generator clears and reseeds
symbolTick out 1 one-cycle pulse: advance displayed symbol
countEn out 1 user counter enable
answerSig out 1 one-cycle pulse starting the answer period
roundNum out 4 current round, 1-based, 0 in IDLE
score out 4 correct answers this game
secLeft out 4 seconds remaining in a timed phase, 0 otherwise
gameDone out 1 high in DONE

Behaviour:
- Reset (async, Rst_n=0): phase=IDLE, all outputs 0. All outputs are registered.
- States and encodings: IDLE=0, READY=1, SHOW=2, ANSWER=3, POST=4, DONE=5.
- Timed phases:
  - On entry, secLeft is loaded with the phase's *_SEC value.
  - On each Clk1Hz: if secLeft==1, exit the phase; otherwise decrement secLeft.
  - A tick in the entry cycle itself is ignored.
  - secLeft is 0 in IDLE and DONE.
- IDLE / DONE + startBtn:
  - Next state READY; roundNum=1, score=0.
  - newRound pulses on the cycle READY is entered.
- READY: after READY_SEC ticks, go to SHOW.
- SHOW:
  - countEn=1 for every cycle in SHOW, and is cleared immediately if stopCount=1.
  - symbolTick is the Clk1Hz tick seen in SHOW, registered one cycle late.
  - After SHOW_SEC ticks, go to ANSWER; countEn=0 from the first ANSWER cycle.
- ANSWER:
  - answerSig=1 for exactly the first cycle in ANSWER.
  - On postSig: if userCount==trueCount (sampled that cycle), score+1, saturating at 15. Then go to POST.
  - If ANSWER_TIMEOUT_SEC ticks pass with no postSig, go to POST with no score change.
  - postSig and the final timeout tick in the same cycle: postSig wins and the answer is scored.
- POST: after POST_SEC ticks:
  - If roundNum==NUM_ROUNDS, go to DONE.
  - Otherwise roundNum+1, newRound pulse, go to READY.
- DONE: gameDone=1; roundNum and score are held.
- abortBtn in any non-IDLE state: next cycle phase=IDLE and all outputs cleared, including score.
- Priority: Rst_n > abortBtn > startBtn > postSig > Clk1Hz.
- startBtn in READY, SHOW, ANSWER or POST is ignored. postSig outside ANSWER is ignored.
- Inputs are already synchronous to Clk100M; no synchronizers are needed.

Decomposition:
- Package symcounter_pkg: phase encodings (PH_IDLE..PH_DONE), 3-bit phase width, score width (4).
- Sub-module sec_timer: 4-bit loadable down-counter.
  - Inputs: load, loadVal, tick.
  - Outputs: secLeft, expire pulse (tick while secLeft==1).
  - Instanced once and reloaded on every phase entry.

Test Plan:
Bench parameters: READY_SEC=1, SHOW_SEC=2, ANSWER_TIMEOUT_SEC=3, POST_SEC=1, NUM_ROUNDS=2; Clk1Hz every 100 cycles, as in the existing benches.
1. Reset then startBtn -> phase goes 0→1, newRound pulses once, roundNum=1, score=0; after 1 tick phase=2 and countEn=1.
2. In SHOW -> exactly 2 symbolTick pulses, each 1 cycle after its Clk1Hz; then phase=3, countEn=0, one answerSig pulse.
3. ANSWER with userCount=10, trueCount=10, postSig -> score=1, phase=4; after 1 tick, roundNum=2, newRound pulses, phase=1.
4. Round 2 with userCount=7, trueCount=9, no postSig -> forced to POST after 3 ticks, score stays 1; after POST, phase=5, gameDone=1.
5. postSig coincident with the 3rd timeout tick, userCount==trueCount -> score increments.
6. abortBtn mid-SHOW -> next cycle phase=0, all outputs 0. Rst_n low mid-ANSWER -> immediate async clear. startBtn during SHOW -> no effect.
